config_frame_rx: RTL and testbench

CONFIG_FRAME_RX -- requirements
Module: config_frame_rx

---
 rtl/config_frame_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_config_frame_rx.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_rx.sv
// Configuration bitstream receiver: hunts for the sync word, parses commands and streams frame data.
// Optional CRC-16 frame checking is built only when CFG_RX_CRC_CHECK_EN is defined.
module config_frame_rx #(
    parameter int FRAME_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic [15:0] m_addr,
    output logic [11:0] m_index,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] frame_cnt,
    output logic        done,
    output logic        err,
    output logic        crc_err
);

    typedef enum logic [2:0] {
        HUNT,
        OPC,
        OPR,
        ADDR,
        DATA,
        CRC,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] SYNC_WORD  = 32'hFFFF_BDB3;
    localparam logic [7:0]  OP_NOOP    = 8'hFF;
    localparam logic [7:0]  OP_INIT    = 8'h46;
    localparam logic [7:0]  OP_WADDR   = 8'hB4;
    localparam logic [7:0]  OP_PROG    = 8'h82;
    localparam logic [7:0]  OP_DONE    = 8'h5E;
    localparam logic [11:0] LAST_INDEX = 12'(FRAME_BYTES - 1);

    state_t      state;
    state_t      state_nx;
    // Only 24 bits of history are stored; the incoming byte completes the 32-bit window.
    logic [23:0] sync_sr;
    logic [7:0]  opcode;
    logic [7:0]  prev_byte;
    logic [1:0]  cnt;
    logic [15:0] addr;
    logic [15:0] frames_left;
    logic [11:0] index;
    logic        accept;
    logic        last_data;

    assign accept    = s_valid && s_ready;
    assign last_data = (index == LAST_INDEX);
    assign m_data    = s_data;
    assign m_addr    = addr;
    assign m_index   = index;
    assign done      = (state == DONE);
    assign err       = (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        s_ready  = 1'b1;
        m_valid  = 1'b0;
        case (state)
            HUNT: begin
                if (accept && ({sync_sr, s_data} == SYNC_WORD)) begin
                    state_nx = OPC;
                end
            end
            OPC: begin
                if (accept) begin
                    case (s_data)
                        OP_NOOP:                            state_nx = OPC;
                        OP_INIT, OP_WADDR, OP_PROG, OP_DONE: state_nx = OPR;
                        default:                            state_nx = ERR;
                    endcase
                end
            end
            OPR: begin
                if (accept && (cnt == 2'd2)) begin
                    case (opcode)
                        OP_INIT:  state_nx = OPC;
                        OP_WADDR: state_nx = ADDR;
                        OP_PROG:  state_nx = ({prev_byte, s_data} == 16'd0) ? OPC : DATA;
                        OP_DONE:  state_nx = DONE;
                        default:  state_nx = ERR;
                    endcase
                end
            end
            ADDR: begin
                if (accept && (cnt == 2'd3)) begin
                    state_nx = OPC;
                end
            end
            DATA: begin
                s_ready = m_ready;
                m_valid = s_valid;
                if (accept && last_data) begin
                    state_nx = CRC;
                end
            end
            CRC: begin
                if (accept && (cnt == 2'd1)) begin
                    state_nx = (frames_left == 16'd1) ? OPC : DATA;
                end
            end
            DONE:    state_nx = DONE;
            ERR:     state_nx = ERR;
            default: state_nx = HUNT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sr     <= '0;
            opcode      <= '0;
            prev_byte   <= '0;
            cnt         <= '0;
            addr        <= '0;
            frames_left <= '0;
            index       <= '0;
            frame_cnt   <= '0;
        end else if (accept) begin
            case (state)
                HUNT: begin
                    sync_sr <= {sync_sr[15:0], s_data};
                end
                OPC: begin
                    opcode <= s_data;
                    cnt    <= 2'd0;
                end
                OPR: begin
                    prev_byte <= s_data;
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd2) begin
                        cnt <= 2'd0;
                        if (opcode == OP_INIT) begin
                            addr <= 16'd0;
                        end
                        if (opcode == OP_PROG) begin
                            frames_left <= {prev_byte, s_data};
                        end
                    end
                end
                ADDR: begin
                    // Upper address bytes shift past prev_byte and are dropped.
                    prev_byte <= s_data;
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        addr <= {prev_byte, s_data};
                        cnt  <= 2'd0;
                    end
                end
                DATA: begin
                    if (last_data) begin
                        index <= 12'd0;
                        cnt   <= 2'd0;
                    end else begin
                        index <= index + 12'd1;
                    end
                end
                CRC: begin
                    prev_byte <= s_data;
                    if (cnt == 2'd1) begin
                        cnt         <= 2'd0;
                        addr        <= addr + 16'd1;
                        frame_cnt   <= frame_cnt + 16'd1;
                        frames_left <= frames_left - 16'd1;
                    end else begin
                        cnt <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CFG_RX_CRC_CHECK_EN
    logic [15:0] crc_acc;
    logic        crc_err_q;

    // CRC-16/0x8005, MSB first, applied one byte at a time.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h8005;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_acc   <= '0;
            crc_err_q <= 1'b0;
        end else if (accept && (state == DATA)) begin
            crc_acc <= crc16_byte(crc_acc, s_data);
        end else if (accept && (state == CRC) && (cnt == 2'd1)) begin
            if ({prev_byte, s_data} != crc_acc) begin
                crc_err_q <= 1'b1;
            end
            crc_acc <= 16'd0;
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_config_frame_rx.sv
// Self-checking bench for config_frame_rx: builds command streams with a stream-level model of
// the expected frame transfers and status, then drives them with random gaps and back-pressure.
module tb_config_frame_rx;

    localparam int FB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic [15:0] m_addr;
    logic [11:0] m_index;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] frame_cnt;
    logic        done;
    logic        err;
    logic        crc_err;

    config_frame_rx #(.FRAME_BYTES(FB)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_index   (m_index),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_cnt (frame_cnt),
        .done      (done),
        .err       (err),
        .crc_err   (crc_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef logic [35:0] xfer_t;   // {data, addr, index}
    xfer_t       exp_q[$];
    xfer_t       got_q[$];
    logic [7:0]  stream[$];
    logic [15:0] model_addr;
    logic [15:0] model_fcnt;
    bit          model_crc_err;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: ready_manual
    bit          ready_manual = 1'b1;
    bit          gap_en = 1'b0;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = ready_manual;
        endcase
    end

    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back({m_data, m_addr, m_index});
    end

    // Reference CRC as polynomial long division of the message augmented by 16 zero bits.
    function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
        logic [16:0] r;
        bit          b;
        int          nbits;
        r = '0;
        nbits = msg.size() * 8;
        for (int k = 0; k < nbits + 16; k++) begin
            b = (k < nbits) ? msg[k / 8][7 - (k % 8)] : 1'b0;
            r = {r[15:0], b};
            if (r[16]) r = r ^ 17'h18005;
        end
        return r[15:0];
    endfunction

    task automatic clear_model();
        got_q.delete();
        exp_q.delete();
        stream.delete();
        model_addr    = 16'd0;
        model_fcnt    = 16'd0;
        model_crc_err = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic push_preamble();
        stream.push_back(8'hFF); stream.push_back(8'hFF);
        stream.push_back(8'hBD); stream.push_back(8'hB3);
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [23:0] operands);
        stream.push_back(op);
        stream.push_back(operands[23:16]);
        stream.push_back(operands[15:8]);
        stream.push_back(operands[7:0]);
    endtask

    task automatic push_write_addr(input logic [23:0] operands, input logic [31:0] a);
        push_cmd(8'hB4, operands);
        stream.push_back(a[31:24]); stream.push_back(a[23:16]);
        stream.push_back(a[15:8]);  stream.push_back(a[7:0]);
        model_addr = a[15:0];
    endtask

    task automatic push_prog(input int n, input bit zero_data, input int bad_frame);
        logic [7:0]  fr[$];
        logic [7:0]  d;
        logic [15:0] c;
        push_cmd(8'h82, {8'($urandom), 16'(n)});
        for (int f = 0; f < n; f++) begin
            fr.delete();
            for (int i = 0; i < FB; i++) begin
                d = zero_data ? 8'h00 : 8'($urandom);
                fr.push_back(d);
                stream.push_back(d);
                exp_q.push_back({d, model_addr, 12'(i)});
            end
            c = crc_ref(fr);
            if (f == bad_frame) begin
                c = c ^ 16'h0001;
`ifdef CFG_RX_CRC_CHECK_EN
                model_crc_err = 1'b1;
`endif
            end
            stream.push_back(c[15:8]);
            stream.push_back(c[7:0]);
            model_addr = model_addr + 16'd1;
            model_fcnt = model_fcnt + 16'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit idle_chk);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        s_data = b;
        s_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = (s_ready === 1'b1);
            if (idle_chk) begin
                checks++;
                if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_handshake: m_valid=%b s_ready=%b, required m_valid=0 s_ready=1", m_valid, s_ready);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h not accepted within 200 cycles", b);
        end
    endtask

    task automatic send_bytes(input int count, input bit idle_chk);
        for (int i = 0; i < count && stream.size() > 0; i++) send_byte(stream.pop_front(), idle_chk);
    endtask

    task automatic test_reset();
        do_reset();
        push_preamble();
        push_write_addr(24'h0, 32'h0000ABCD);
        push_cmd(8'h82, 24'h000001);
        stream.push_back(8'h11); stream.push_back(8'h22); stream.push_back(8'h33);
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (m_addr !== 16'hABCD || m_index !== 12'd3) begin
            errors++;
            $display("FAIL reset_setup: m_addr=%h m_index=%0d, required ABCD and 3", m_addr, m_index);
        end
        do_reset();
        checks++;
        if ({done, err, crc_err, m_valid, s_ready, frame_cnt, m_addr, m_index} !== {5'b00001, 16'd0, 16'd0, 12'd0}) begin
            errors++;
            $display("FAIL reset_state: done=%b err=%b crc_err=%b m_valid=%b s_ready=%b frame_cnt=%h m_addr=%h m_index=%h, required 0 0 0 0 1 0 0 0",
                     done, err, crc_err, m_valid, s_ready, frame_cnt, m_addr, m_index);
        end
    endtask

    task automatic test_init_done();
        logic [7:0] seq[13] = '{8'h00, 8'hFF, 8'hFF, 8'hBD, 8'hB3, 8'h46, 8'h00, 8'h00, 8'h00,
                                8'h5E, 8'h00, 8'h00, 8'h00};
        do_reset();
        foreach (seq[i]) stream.push_back(seq[i]);
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || frame_cnt !== 16'd0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL init_done: done=%b err=%b frame_cnt=%0d xfers=%0d, required 1 0 0 0", done, err, frame_cnt, got_q.size());
        end
    endtask

    task automatic test_prog_zero(input int bad_frame);
        do_reset();
        ready_mode = 0;
        gap_en = 1'b0;
        push_preamble();
        push_write_addr(24'h0, 32'h00001234);
        push_prog(2, 1'b1, bad_frame);
        push_cmd(8'h5E, 24'h0);
        send_bytes(stream.size() - (FB + 2) - 4, 1'b0);
        checks++;
        if (crc_err !== model_crc_err || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL prog_first_frame: crc_err=%b frame_cnt=%0d, required %b 1", crc_err, frame_cnt, model_crc_err);
        end
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL prog_count: got %0d transfers, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL prog_xfer[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 16'd2 || crc_err !== model_crc_err || done !== 1'b1 || m_addr !== 16'h1236) begin
            errors++;
            $display("FAIL prog_status: frame_cnt=%0d crc_err=%b done=%b m_addr=%h, required 2 %b 1 1236",
                     frame_cnt, crc_err, done, m_addr, model_crc_err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ready_mode = 1;
        gap_en = 1'b1;
        push_preamble();
        push_write_addr(24'($urandom), {16'($urandom), 16'hFFFF});
        push_prog(2, 1'b0, -1);
        push_cmd(8'h5E, 24'($urandom));
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (got_q.size() != 2 * FB || got_q[0][27:12] !== 16'hFFFF || got_q[FB][27:12] !== 16'h0000) begin
            errors++;
            $display("FAIL addr_wrap: xfers=%0d first addr=%h second addr=%h, required %0d FFFF 0000",
                     got_q.size(), got_q.size() > 0 ? got_q[0][27:12] : 16'hxxxx,
                     got_q.size() > FB ? got_q[FB][27:12] : 16'hxxxx, 2 * FB);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_xfer[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (m_addr !== model_addr || frame_cnt !== 16'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_status: m_addr=%h frame_cnt=%0d done=%b, required %h 2 1", m_addr, frame_cnt, done, model_addr);
        end
    endtask

    task automatic test_error();
        do_reset();
        ready_mode = 1;
        gap_en = 1'b1;
        push_preamble();
        stream.push_back(8'h77);
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL bad_opcode: err=%b done=%b, required 1 0", err, done);
        end
        for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
        stream.push_back(8'h82); stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h01);
        send_bytes(stream.size(), 1'b1);
        checks++;
        if (err !== 1'b1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL err_absorb: err=%b xfers=%0d, required 1 0", err, got_q.size());
        end
        do_reset();
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: err=%b done=%b, required 0 0", err, done);
        end
        push_preamble();
        push_cmd(8'h5E, 24'h0);
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_rehunt: done=%b err=%b, required 1 0", done, err);
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready_mode = 2;
        ready_manual = 1'b1;
        gap_en = 1'b0;
        push_preamble();
        push_write_addr(24'h0, 32'h00000042);
        push_prog(1, 1'b0, -1);
        push_cmd(8'h5E, 24'h0);
        send_bytes(16 + 6, 1'b0);
        s_data = stream[0];
        s_valid = 1'b1;
        ready_manual = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_index !== 12'd6) begin
                errors++;
                $display("FAIL stall_cycle%0d: s_ready=%b m_index=%0d, required 0 6", c, s_ready, m_index);
            end
            @(posedge clk); #1;
        end
        ready_manual = 1'b1;
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d transfers, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_xfer[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== 16'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_status: frame_cnt=%0d done=%b, required 1 1", frame_cnt, done);
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        ready_mode = 0;
        gap_en = 1'b0;
        push_preamble();
        push_write_addr(24'h0, 32'h00000100);
        push_prog(1, 1'b0, -1);
        send_bytes(16 + 5, 1'b0);
        s_data = 8'($urandom);
        s_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_index !== 12'd0 || m_addr !== 16'd0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: m_valid=%b m_index=%0d m_addr=%h frame_cnt=%0d, required 0 0 0000 0",
                     m_valid, m_index, m_addr, frame_cnt);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        clear_model();
        push_preamble();
        push_cmd(8'h5E, 24'h0);
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (done !== 1'b1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_frame_after: done=%b xfers=%0d, required 1 0", done, got_q.size());
        end
    endtask

    task automatic test_random(input int seq_id);
        int kind;
        do_reset();
        ready_mode = 1;
        gap_en = 1'b1;
        repeat ($urandom_range(0, 6)) stream.push_back(8'($urandom_range(0, 127)));
        push_preamble();
        repeat (8) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: stream.push_back(8'hFF);
                1: begin
                    push_cmd(8'h46, 24'($urandom));
                    model_addr = 16'd0;
                end
                2: push_write_addr(24'($urandom), $urandom);
                default: push_prog($urandom_range(0, 2), 1'b0, ($urandom_range(0, 3) == 0) ? 0 : -1);
            endcase
        end
        push_cmd(8'h5E, 24'($urandom));
        repeat (3) stream.push_back(8'($urandom));
        send_bytes(stream.size(), 1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d transfers, required %0d", seq_id, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand%0d_xfer[%0d]: got %h, required %h", seq_id, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (frame_cnt !== model_fcnt || m_addr !== model_addr || crc_err !== model_crc_err || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_status: frame_cnt=%0d m_addr=%h crc_err=%b done=%b err=%b, required %0d %h %b 1 0",
                     seq_id, frame_cnt, m_addr, crc_err, done, err, model_fcnt, model_addr, model_crc_err);
        end
    endtask

    initial begin
        test_reset();
        test_init_done();
        test_prog_zero(-1);
        test_prog_zero(0);
        test_wrap();
        test_error();
        test_stall();
        test_reset_mid_frame();
        for (int s = 0; s < 4; s++) test_random(s);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
